mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage RV32I core; consumes EX outputs, owns the EX_MEM and MEM_WB pipeline registers.
- Drives the data-memory request/ready handshake.
- Publishes the forwarding sources (EX_MEM_*, MEM_WB_*) that the EX hazard checker consumes.
- Raises MEM_kick_up to freeze upstream stages while a memory access is outstanding.

Parameters:
MEM_TIMEOUT, 16, max cycles in REQ without dmem_ready before abort (>=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
EX_kick_up  input  1  EX stalled this cycle; EX_MEM must load a bubble
EX_rd  input  5  destination register
EX_ALU_result  input  32  ALU result / effective address
EX_rs2_data  input  32  store data (already forwarded)
EX_funct3  input  3  access size/sign
EX_memread  input  1  load
EX_memwrite  input  1  store
EX_memtoreg  input  1  writeback selects load data
EX_regwrite  input  1  writes rd
EX_MEM_rd  output  5  forwarding source
EX_MEM_ALU_result  output  32  forwarding source
EX_MEM_regwrite  output  1  forwarding source
EX_MEM_memtoreg  output  1  load in MEM; EX must not forward
MEM_WB_rd  output  5  writeback register
MEM_WB_result  output  32  writeback data
MEM_WB_regwrite  output  1  writeback enable
MEM_kick_up  output  1  stall request to IF/ID/EX
MEM_fault  output  1  one-cycle pulse: misaligned or timed-out access
dmem_req  output  1  request valid
dmem_we  output  1  write
dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  output  32  lane-shifted store data
dmem_wstrb  output  4  byte strobes
dmem_ready  input  1  access complete this cycle
dmem_rdata  input  32  read word, valid with dmem_ready

Behaviour:
- Reset (async): all EX_MEM/MEM_WB fields 0, state IDLE, dmem_req=0, MEM_kick_up=0, MEM_fault=0, timeout counter 0.
- FSM states: IDLE, REQ.
- dmem_req = (state==REQ); dmem_we, dmem_addr, dmem_wdata and dmem_wstrb are driven from EX_MEM and held stable while in REQ.
- EX_MEM load:
  - When MEM_kick_up=0: EX_MEM captures EX_* on each edge.
  - If EX_kick_up=1, EX_MEM captures a bubble instead (regwrite/memread/memwrite/memtoreg = 0).
  - When MEM_kick_up=1: EX_MEM holds.
- Entering REQ: on the edge EX_MEM captures an aligned memread or memwrite, state becomes REQ. Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0):
  - no REQ is entered;
  - MEM_fault pulses in the next cycle;
  - MEM_WB receives a bubble.
- MEM_kick_up = (state==REQ) && !dmem_ready, combinational.
- Request completion: on an edge with state==REQ and dmem_ready=1:
  - state goes to IDLE;
  - MEM_WB takes rd, regwrite (forced 0 for stores), and result (aligned load data if memtoreg, else ALU result).
- A new op in EX is captured into EX_MEM on the same edge as the completion, so back-to-back accesses re-enter REQ with no idle cycle.
- Non-memory op latency: MEM_WB updates one edge after EX_MEM. A load whose ready arrives in its first REQ cycle has the same latency, with no stall.
- During a stall, MEM_WB loads a bubble every cycle (regwrite=0).
- Timeout:
  - The counter increments each REQ cycle without ready and clears on leaving REQ.
  - When it reaches MEM_TIMEOUT-1 without ready, on that edge: state goes to IDLE, MEM_WB gets a bubble, and MEM_fault pulses in the following cycle.
  - If dmem_ready arrives in that same cycle, ready wins: normal completion, no fault.
- Load alignment:
  - LB/LBU select byte addr[1:0]; LH/LHU select halfword addr[1].
  - Sign- or zero-extend to 32 bits; LW passes the word through.
- Store alignment:
  - SB: wdata = byte replicated ×4, wstrb = 1<<addr[1:0].
  - SH: wdata = halfword ×2, wstrb = 4'b0011 or 4'b1100.
  - SW: wstrb = 4'b1111.
- Reset asserted mid-REQ: dmem_req drops immediately and the pending access is discarded.
- Undefined funct3 (3, 6, 7) on a memory op is treated as LW/SW width.

Decomposition:
- Shared package core_pkg: funct3 constants (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5), mem FSM state encoding, XLEN=32.
- Sub-module mem_align: purely combinational load extract/extend, store lane shift and strobe generation, and misalign detect.
- The FSM, counter and pipeline registers stay in mem_stage.

Test Plan:
- ADD rd=5, result 0x1234 with no mem op -> EX_MEM_rd=5 after edge 1; MEM_WB_result=0x1234 with regwrite=1 after edge 2; no stall.
- LW addr 0x100 with dmem_ready after 3 cycles, rdata 0xDEADBEEF -> MEM_kick_up high 3 cycles; MEM_WB_result=0xDEADBEEF; EX_MEM held; stall-cycle MEM_WB regwrite=0.
- LB addr 0x103, rdata 0x80FFFFFF -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102, rdata 0xBEEF0000 -> 0x0000BEEF.
- SH addr 0x202, data 0x0000ABCD -> dmem_wstrb=4'b1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200, dmem_we=1; MEM_WB_regwrite=0.
- LW addr 0x101 -> no dmem_req, MEM_fault single pulse, MEM_WB bubble; dmem_ready never asserted with MEM_TIMEOUT=16 -> abort after 15 REQ cycles with MEM_fault pulse, and ready on the 15th cycle completes normally.
- Reset pulsed mid-REQ -> dmem_req, MEM_kick_up and all EX_MEM/MEM_WB outputs go to 0 without a clock edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: load/store funct3 encodings, MEM FSM states, datapath width.
package core_pkg;
   localparam int XLEN = 32;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } mem_state_t;
endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic for the MEM stage: load extract/extend, store lane
// replication and strobes, plus misalignment detection for the op arriving from EX.
module mem_align
   import core_pkg::*;
(
   input  logic [2:0]      i_funct3,
   input  logic [1:0]      i_addr_lo,
   input  logic [XLEN-1:0] i_store_data,
   input  logic [XLEN-1:0] i_rdata,
   output logic [XLEN-1:0] o_load_data,
   output logic [XLEN-1:0] o_wdata,
   output logic [3:0]      o_wstrb,
   input  logic [2:0]      i_chk_funct3,
   input  logic [1:0]      i_chk_addr_lo,
   output logic            o_misaligned
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr_lo)
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   // funct3[1:0] picks the width; undefined encodings fall through to word.
   always_comb begin
      o_load_data = i_rdata;
      o_wdata     = i_store_data;
      o_wstrb     = 4'b1111;
      case (i_funct3[1:0])
         F3_B[1:0]: begin
            o_load_data = i_funct3[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            o_wdata     = {4{i_store_data[7:0]}};
            o_wstrb     = 4'b0001 << i_addr_lo;
         end
         F3_H[1:0]: begin
            o_load_data = i_funct3[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            o_wdata     = {2{i_store_data[15:0]}};
            o_wstrb     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            o_load_data = i_rdata;
            o_wdata     = i_store_data;
            o_wstrb     = 4'b1111;
         end
      endcase
   end

   always_comb begin
      o_misaligned = 1'b0;
      case (i_chk_funct3[1:0])
         F3_B[1:0]: o_misaligned = 1'b0;
         F3_H[1:0]: o_misaligned = i_chk_addr_lo[0];
         default:   o_misaligned = |i_chk_addr_lo;
      endcase
   end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX_MEM/MEM_WB registers, data-memory request FSM with timeout,
// upstream stall generation and forwarding-source outputs.
module mem_stage
   import core_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            EX_kick_up,
   input  logic [4:0]      EX_rd,
   input  logic [XLEN-1:0] EX_ALU_result,
   input  logic [XLEN-1:0] EX_rs2_data,
   input  logic [2:0]      EX_funct3,
   input  logic            EX_memread,
   input  logic            EX_memwrite,
   input  logic            EX_memtoreg,
   input  logic            EX_regwrite,
   output logic [4:0]      EX_MEM_rd,
   output logic [XLEN-1:0] EX_MEM_ALU_result,
   output logic            EX_MEM_regwrite,
   output logic            EX_MEM_memtoreg,
   output logic [4:0]      MEM_WB_rd,
   output logic [XLEN-1:0] MEM_WB_result,
   output logic            MEM_WB_regwrite,
   output logic            MEM_kick_up,
   output logic            MEM_fault,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_wstrb,
   input  logic            dmem_ready,
   input  logic [XLEN-1:0] dmem_rdata
);
   localparam int              CW      = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0]   TO_LAST = CW'(MEM_TIMEOUT - 2);

   mem_state_t      r_state, w_state_next;
   logic [CW-1:0]   r_cnt;
   logic [4:0]      r_exm_rd;
   logic [XLEN-1:0] r_exm_alu, r_exm_rs2;
   logic [2:0]      r_exm_f3;
   logic            r_exm_memwrite, r_exm_memtoreg, r_exm_regwrite;
   logic            r_exm_kill;
   logic [4:0]      r_wb_rd;
   logic [XLEN-1:0] r_wb_result;
   logic            r_wb_regwrite;

   logic            w_stall, w_ex_mem_op, w_ex_misal, w_enter_req, w_timeout, w_wb_valid;
   logic [XLEN-1:0] w_load_data;

   mem_align u_align (
      .i_funct3      (r_exm_f3),
      .i_addr_lo     (r_exm_alu[1:0]),
      .i_store_data  (r_exm_rs2),
      .i_rdata       (dmem_rdata),
      .o_load_data   (w_load_data),
      .o_wdata       (dmem_wdata),
      .o_wstrb       (dmem_wstrb),
      .i_chk_funct3  (EX_funct3),
      .i_chk_addr_lo (EX_ALU_result[1:0]),
      .o_misaligned  (w_ex_misal)
   );

   assign w_stall     = (r_state == ST_REQ) && !dmem_ready;
   assign w_ex_mem_op = !EX_kick_up && (EX_memread || EX_memwrite);
   assign w_enter_req = w_ex_mem_op && !w_ex_misal;
   assign w_timeout   = w_stall && (r_cnt == TO_LAST);
   // A killed op (misaligned or timed out) still sits in EX_MEM for one cycle and must not write back.
   assign w_wb_valid  = !w_stall && !r_exm_kill;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_enter_req) w_state_next = ST_REQ;
         ST_REQ: begin
            if (dmem_ready)     w_state_next = w_enter_req ? ST_REQ : ST_IDLE;
            else if (w_timeout) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt          <= '0;
         r_exm_rd       <= '0;
         r_exm_alu      <= '0;
         r_exm_rs2      <= '0;
         r_exm_f3       <= '0;
         r_exm_memwrite <= 1'b0;
         r_exm_memtoreg <= 1'b0;
         r_exm_regwrite <= 1'b0;
         r_exm_kill     <= 1'b0;
      end else if (!w_stall) begin
         r_cnt          <= '0;
         r_exm_rd       <= EX_rd;
         r_exm_alu      <= EX_ALU_result;
         r_exm_rs2      <= EX_rs2_data;
         r_exm_f3       <= EX_funct3;
         r_exm_memwrite <= EX_memwrite && !EX_kick_up;
         r_exm_memtoreg <= EX_memtoreg && !EX_kick_up;
         r_exm_regwrite <= EX_regwrite && !EX_kick_up;
         r_exm_kill     <= w_ex_mem_op && w_ex_misal;
      end else if (w_timeout) begin
         r_cnt      <= '0;
         r_exm_kill <= 1'b1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wb_rd       <= '0;
         r_wb_result   <= '0;
         r_wb_regwrite <= 1'b0;
      end else if (w_wb_valid) begin
         r_wb_rd       <= r_exm_rd;
         r_wb_result   <= r_exm_memtoreg ? w_load_data : r_exm_alu;
         r_wb_regwrite <= r_exm_regwrite && !r_exm_memwrite;
      end else begin
         r_wb_rd       <= '0;
         r_wb_result   <= '0;
         r_wb_regwrite <= 1'b0;
      end
   end

   assign EX_MEM_rd         = r_exm_rd;
   assign EX_MEM_ALU_result = r_exm_alu;
   assign EX_MEM_regwrite   = r_exm_regwrite;
   assign EX_MEM_memtoreg   = r_exm_memtoreg;
   assign MEM_WB_rd         = r_wb_rd;
   assign MEM_WB_result     = r_wb_result;
   assign MEM_WB_regwrite   = r_wb_regwrite;
   assign MEM_kick_up       = w_stall;
   assign MEM_fault         = r_exm_kill;
   assign dmem_req          = (r_state == ST_REQ);
   assign dmem_we           = r_exm_memwrite;
   assign dmem_addr         = {r_exm_alu[31:2], 2'b00};
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load stall, lane alignment, stores,
// misalignment, timeout abort, back-to-back loads and asynchronous reset.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic        EX_kick_up;
   logic [4:0]  EX_rd;
   logic [31:0] EX_ALU_result, EX_rs2_data;
   logic [2:0]  EX_funct3;
   logic        EX_memread, EX_memwrite, EX_memtoreg, EX_regwrite;
   logic [4:0]  EX_MEM_rd;
   logic [31:0] EX_MEM_ALU_result;
   logic        EX_MEM_regwrite, EX_MEM_memtoreg;
   logic [4:0]  MEM_WB_rd;
   logic [31:0] MEM_WB_result;
   logic        MEM_WB_regwrite, MEM_kick_up, MEM_fault;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   mem_stage #(.MEM_TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .EX_kick_up(EX_kick_up), .EX_rd(EX_rd),
      .EX_ALU_result(EX_ALU_result), .EX_rs2_data(EX_rs2_data), .EX_funct3(EX_funct3),
      .EX_memread(EX_memread), .EX_memwrite(EX_memwrite), .EX_memtoreg(EX_memtoreg),
      .EX_regwrite(EX_regwrite), .EX_MEM_rd(EX_MEM_rd), .EX_MEM_ALU_result(EX_MEM_ALU_result),
      .EX_MEM_regwrite(EX_MEM_regwrite), .EX_MEM_memtoreg(EX_MEM_memtoreg),
      .MEM_WB_rd(MEM_WB_rd), .MEM_WB_result(MEM_WB_result), .MEM_WB_regwrite(MEM_WB_regwrite),
      .MEM_kick_up(MEM_kick_up), .MEM_fault(MEM_fault), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
   );

   task automatic drive(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [2:0] f3, input logic mr, input logic mw,
                        input logic mtr, input logic rw);
      EX_kick_up = 1'b0; EX_rd = rd; EX_ALU_result = alu; EX_rs2_data = rs2;
      EX_funct3 = f3; EX_memread = mr; EX_memwrite = mw; EX_memtoreg = mtr; EX_regwrite = rw;
   endtask

   task automatic nop();
      drive(5'd0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1; dmem_ready = 1'b0; dmem_rdata = 32'h0; nop();
      @(negedge clk);
      total_cnt++; if (dmem_req !== 1'b0 || MEM_kick_up !== 1'b0 || MEM_fault !== 1'b0) $display("FAIL reset_ctrl: got req=%b kick=%b fault=%b want 0 0 0", dmem_req, MEM_kick_up, MEM_fault); else pass_cnt++;
      total_cnt++; if (EX_MEM_rd !== 5'd0 || EX_MEM_regwrite !== 1'b0 || MEM_WB_regwrite !== 1'b0 || MEM_WB_result !== 32'h0) $display("FAIL reset_regs: got exm_rd=%0d exm_rw=%b wb_rw=%b wb_res=%h want zeros", EX_MEM_rd, EX_MEM_regwrite, MEM_WB_regwrite, MEM_WB_result); else pass_cnt++;
      reset = 1'b0;
      $display("tx reset released");
   endtask

   task automatic test_alu();
      drive(5'd5, 32'h1234, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      total_cnt++; if (EX_MEM_rd !== 5'd5 || EX_MEM_regwrite !== 1'b1 || MEM_kick_up !== 1'b0) $display("FAIL alu_exmem: got rd=%0d rw=%b kick=%b want 5 1 0", EX_MEM_rd, EX_MEM_regwrite, MEM_kick_up); else pass_cnt++;
      nop();
      @(negedge clk);
      total_cnt++; if (MEM_WB_result !== 32'h1234 || MEM_WB_rd !== 5'd5 || MEM_WB_regwrite !== 1'b1) $display("FAIL alu_memwb: got res=%h rd=%0d rw=%b want 00001234 5 1", MEM_WB_result, MEM_WB_rd, MEM_WB_regwrite); else pass_cnt++;
      drive(5'd6, 32'h55, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      EX_kick_up = 1'b1;
      @(negedge clk);
      total_cnt++; if (EX_MEM_regwrite !== 1'b0) $display("FAIL ex_bubble: got rw=%b want 0", EX_MEM_regwrite); else pass_cnt++;
      nop();
      @(negedge clk);
      $display("tx ALU rd=5 result=%h", 32'h1234);
   endtask

   task automatic test_lw_stall();
      dmem_ready = 1'b0;
      drive(5'd7, 32'h100, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      total_cnt++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_we !== 1'b0) $display("FAIL lw_req: got req=%b addr=%h we=%b want 1 00000100 0", dmem_req, dmem_addr, dmem_we); else pass_cnt++;
      total_cnt++; if (EX_MEM_memtoreg !== 1'b1) $display("FAIL lw_memtoreg: got %b want 1", EX_MEM_memtoreg); else pass_cnt++;
      drive(5'd9, 32'h999, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         total_cnt++; if (MEM_kick_up !== 1'b1 || EX_MEM_rd !== 5'd7 || EX_MEM_ALU_result !== 32'h100) $display("FAIL lw_hold%0d: got kick=%b rd=%0d alu=%h want 1 7 00000100", i, MEM_kick_up, EX_MEM_rd, EX_MEM_ALU_result); else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++; if (MEM_WB_regwrite !== 1'b0) $display("FAIL lw_stall_bubble: got rw=%b want 0", MEM_WB_regwrite); else pass_cnt++;
      dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
      #1;
      total_cnt++; if (MEM_kick_up !== 1'b0) $display("FAIL lw_kick_release: got %b want 0", MEM_kick_up); else pass_cnt++;
      @(negedge clk);
      dmem_ready = 1'b0;
      total_cnt++; if (MEM_WB_result !== 32'hDEADBEEF || MEM_WB_rd !== 5'd7 || MEM_WB_regwrite !== 1'b1) $display("FAIL lw_result: got res=%h rd=%0d rw=%b want deadbeef 7 1", MEM_WB_result, MEM_WB_rd, MEM_WB_regwrite); else pass_cnt++;
      total_cnt++; if (EX_MEM_rd !== 5'd9 || dmem_req !== 1'b0) $display("FAIL lw_next_capture: got rd=%0d req=%b want 9 0", EX_MEM_rd, dmem_req); else pass_cnt++;
      nop();
      @(negedge clk);
      $display("tx LW addr=00000100 data=deadbeef");
   endtask

   task automatic test_load_align();
      logic [2:0]  f3_t  [3] = '{3'd0, 3'd4, 3'd5};
      logic [31:0] adr_t [3] = '{32'h103, 32'h103, 32'h102};
      logic [31:0] rd_t  [3] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'hBEEF0000};
      logic [31:0] exp_t [3] = '{32'hFFFFFF80, 32'h00000080, 32'h0000BEEF};
      for (int i = 0; i < 3; i++) begin
         dmem_ready = 1'b0;
         drive(5'd8, adr_t[i], 32'h0, f3_t[i], 1'b1, 1'b0, 1'b1, 1'b1);
         @(negedge clk);
         nop();
         dmem_ready = 1'b1; dmem_rdata = rd_t[i];
         #1;
         total_cnt++; if (MEM_kick_up !== 1'b0 || dmem_req !== 1'b1) $display("FAIL ld%0d_nostall: got kick=%b req=%b want 0 1", i, MEM_kick_up, dmem_req); else pass_cnt++;
         @(negedge clk);
         dmem_ready = 1'b0;
         total_cnt++; if (MEM_WB_result !== exp_t[i] || MEM_WB_regwrite !== 1'b1) $display("FAIL ld%0d_result: got %h rw=%b want %h 1", i, MEM_WB_result, MEM_WB_regwrite, exp_t[i]); else pass_cnt++;
         $display("tx load f3=%0d addr=%h rdata=%h result=%h", f3_t[i], adr_t[i], rd_t[i], MEM_WB_result);
      end
   endtask

   task automatic test_store_sh();
      dmem_ready = 1'b0;
      drive(5'd3, 32'h202, 32'h0000ABCD, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      nop();
      total_cnt++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h200) $display("FAIL sh_req: got req=%b we=%b addr=%h want 1 1 00000200", dmem_req, dmem_we, dmem_addr); else pass_cnt++;
      total_cnt++; if (dmem_wdata !== 32'hABCDABCD || dmem_wstrb !== 4'b1100) $display("FAIL sh_lanes: got wdata=%h wstrb=%b want abcdabcd 1100", dmem_wdata, dmem_wstrb); else pass_cnt++;
      dmem_ready = 1'b1;
      @(negedge clk);
      dmem_ready = 1'b0;
      total_cnt++; if (MEM_WB_regwrite !== 1'b0 || dmem_req !== 1'b0) $display("FAIL sh_wb: got rw=%b req=%b want 0 0", MEM_WB_regwrite, dmem_req); else pass_cnt++;
      drive(5'd3, 32'h301, 32'h000000EF, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      nop();
      total_cnt++; if (dmem_wdata !== 32'hEFEFEFEF || dmem_wstrb !== 4'b0010 || dmem_addr !== 32'h300) $display("FAIL sb_lanes: got wdata=%h wstrb=%b addr=%h want efefefef 0010 00000300", dmem_wdata, dmem_wstrb, dmem_addr); else pass_cnt++;
      dmem_ready = 1'b1;
      @(negedge clk);
      dmem_ready = 1'b0;
      $display("tx SH addr=00000202 data=0000abcd; SB addr=00000301 data=ef");
   endtask

   task automatic test_misalign();
      dmem_ready = 1'b0;
      drive(5'd4, 32'h101, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      nop();
      total_cnt++; if (dmem_req !== 1'b0 || MEM_fault !== 1'b1 || MEM_kick_up !== 1'b0) $display("FAIL mis_pulse: got req=%b fault=%b kick=%b want 0 1 0", dmem_req, MEM_fault, MEM_kick_up); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (MEM_fault !== 1'b0 || MEM_WB_regwrite !== 1'b0) $display("FAIL mis_after: got fault=%b rw=%b want 0 0", MEM_fault, MEM_WB_regwrite); else pass_cnt++;
      drive(5'd4, 32'h103, 32'h0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      nop();
      total_cnt++; if (dmem_req !== 1'b0 || MEM_fault !== 1'b1) $display("FAIL mis_lhu: got req=%b fault=%b want 0 1", dmem_req, MEM_fault); else pass_cnt++;
      @(negedge clk);
      $display("tx misaligned LW addr=00000101 and LHU addr=00000103");
   endtask

   task automatic test_timeout();
      int n = 0;
      dmem_ready = 1'b0;
      drive(5'd6, 32'h100, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      nop();
      while (dmem_req === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      total_cnt++; if (n !== 15) $display("FAIL to_cycles: got %0d REQ cycles want 15", n); else pass_cnt++;
      total_cnt++; if (MEM_fault !== 1'b1 || MEM_WB_regwrite !== 1'b0 || MEM_kick_up !== 1'b0) $display("FAIL to_abort: got fault=%b rw=%b kick=%b want 1 0 0", MEM_fault, MEM_WB_regwrite, MEM_kick_up); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (MEM_fault !== 1'b0 || MEM_WB_regwrite !== 1'b0 || dmem_req !== 1'b0) $display("FAIL to_after: got fault=%b rw=%b req=%b want 0 0 0", MEM_fault, MEM_WB_regwrite, dmem_req); else pass_cnt++;
      $display("tx LW timeout after %0d cycles", n);
   endtask

   task automatic test_timeout_ready();
      dmem_ready = 1'b0;
      drive(5'd14, 32'h100, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      nop();
      for (int i = 1; i < 15; i++) @(negedge clk);
      total_cnt++; if (dmem_req !== 1'b1) $display("FAIL tr_still_req: got %b want 1", dmem_req); else pass_cnt++;
      dmem_ready = 1'b1; dmem_rdata = 32'h5A5A1234;
      @(negedge clk);
      dmem_ready = 1'b0;
      total_cnt++; if (MEM_fault !== 1'b0 || MEM_WB_result !== 32'h5A5A1234 || MEM_WB_regwrite !== 1'b1 || MEM_WB_rd !== 5'd14) $display("FAIL tr_complete: got fault=%b res=%h rw=%b rd=%0d want 0 5a5a1234 1 14", MEM_fault, MEM_WB_result, MEM_WB_regwrite, MEM_WB_rd); else pass_cnt++;
      @(negedge clk);
      $display("tx LW ready on 15th cycle data=5a5a1234");
   endtask

   task automatic test_back_to_back();
      dmem_ready = 1'b0;
      drive(5'd10, 32'h100, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      drive(5'd11, 32'h104, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
      dmem_ready = 1'b1; dmem_rdata = 32'h11111111;
      @(negedge clk);
      nop();
      total_cnt++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h104 || MEM_WB_result !== 32'h11111111 || MEM_WB_rd !== 5'd10) $display("FAIL b2b_first: got req=%b addr=%h res=%h rd=%0d want 1 00000104 11111111 10", dmem_req, dmem_addr, MEM_WB_result, MEM_WB_rd); else pass_cnt++;
      dmem_rdata = 32'h22222222;
      @(negedge clk);
      dmem_ready = 1'b0;
      total_cnt++; if (dmem_req !== 1'b0 || MEM_WB_result !== 32'h22222222 || MEM_WB_rd !== 5'd11) $display("FAIL b2b_second: got req=%b res=%h rd=%0d want 0 22222222 11", dmem_req, MEM_WB_result, MEM_WB_rd); else pass_cnt++;
      $display("tx back-to-back LW 00000100 / 00000104");
   endtask

   task automatic test_reset_mid_req();
      dmem_ready = 1'b0;
      drive(5'd12, 32'h77, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      drive(5'd13, 32'h100, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      nop();
      total_cnt++; if (dmem_req !== 1'b1 || MEM_WB_rd !== 5'd12 || EX_MEM_rd !== 5'd13) $display("FAIL rst_pre: got req=%b wb_rd=%0d exm_rd=%0d want 1 12 13", dmem_req, MEM_WB_rd, EX_MEM_rd); else pass_cnt++;
      #1 reset = 1'b1;
      #1;
      total_cnt++; if (dmem_req !== 1'b0 || MEM_kick_up !== 1'b0) $display("FAIL rst_async_ctrl: got req=%b kick=%b want 0 0", dmem_req, MEM_kick_up); else pass_cnt++;
      total_cnt++; if (EX_MEM_rd !== 5'd0 || EX_MEM_ALU_result !== 32'h0 || EX_MEM_regwrite !== 1'b0 || EX_MEM_memtoreg !== 1'b0 || MEM_WB_rd !== 5'd0 || MEM_WB_result !== 32'h0 || MEM_WB_regwrite !== 1'b0) $display("FAIL rst_async_regs: got exm_rd=%0d alu=%h rw=%b mtr=%b wb_rd=%0d res=%h wrw=%b want zeros", EX_MEM_rd, EX_MEM_ALU_result, EX_MEM_regwrite, EX_MEM_memtoreg, MEM_WB_rd, MEM_WB_result, MEM_WB_regwrite); else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total_cnt++; if (dmem_req !== 1'b0) $display("FAIL rst_discard: got req=%b want 0", dmem_req); else pass_cnt++;
      $display("tx reset during REQ");
   endtask

   initial begin
      test_reset();
      test_alu();
      test_lw_stall();
      test_load_align();
      test_store_sh();
      test_misalign();
      test_timeout();
      test_timeout_ready();
      test_back_to_back();
      test_reset_mid_req();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
